// File: rtl/midi_rx.sv
// midi_rx: MIDI serial receiver (31250 baud, 8N1) with a small receive FIFO.
//   clock     system clock, rising edge
//   _reset    synchronous active-low reset
//   rxd       raw serial input (asynchronous, idles high)
//   rd        one-cycle pop strobe for the FIFO head
//   clr_err   one-cycle strobe clearing ferr/ovr
//   irq_en    interrupt enable
//   data      FIFO head byte, 8'h00 when empty
//   rx_ready  FIFO not empty
//   count     FIFO occupancy
//   ferr/ovr  sticky framing error / overrun
//   irq       irq_en & (rx_ready | ferr | ovr)
module midi_rx #(
   parameter int DIVISOR = 16,
   parameter int DEPTH   = 4
) (
   input  logic                   clock,
   input  logic                   _reset,
   input  logic                   rxd,
   input  logic                   rd,
   input  logic                   clr_err,
   input  logic                   irq_en,
   output logic [7:0]             data,
   output logic                   rx_ready,
   output logic [$clog2(DEPTH):0] count,
   output logic                   ferr,
   output logic                   ovr,
   output logic                   irq
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam int DW = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;

   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

   logic          sync1_q, sync2_q, prev_q;
   logic [DW-1:0] pre_q;
   state_t        state_q, state_d;
   logic [3:0]    cnt_q, cnt_d;
   logic [2:0]    bit_q, bit_d;
   logic [7:0]    shift_q, shift_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          ferr_q, ferr_d, ovr_q, ovr_d;
   logic [7:0]    mem_q [DEPTH];

   logic tick, fall, push, ferr_set;
   logic full, empty, pop, wr_en, ovr_set;

   // Free-running prescaler; tick on the terminal count only.
   assign tick = (pre_q == DW'(DIVISOR - 1));
   // Falling edge seen on the synchronised line.
   assign fall = prev_q & ~sync2_q;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      bit_d    = bit_q;
      shift_d  = shift_q;
      push     = 1'b0;
      ferr_set = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (fall) begin
               state_d = S_START;
               cnt_d   = 4'd0;
            end
         end
         S_START: begin
            if (tick) begin
               if (cnt_q == 4'd7) begin
                  // Mid start bit: a high line here was only a glitch.
                  if (sync2_q) begin
                     state_d = S_IDLE;
                  end else begin
                     state_d = S_DATA;
                     cnt_d   = 4'd0;
                     bit_d   = 3'd0;
                  end
               end else begin
                  cnt_d = cnt_q + 4'd1;
               end
            end
         end
         S_DATA: begin
            if (tick) begin
               if (cnt_q == 4'd15) begin
                  shift_d = {sync2_q, shift_q[7:1]};
                  cnt_d   = 4'd0;
                  bit_d   = bit_q + 3'd1;
                  if (bit_q == 3'd7) state_d = S_STOP;
               end else begin
                  cnt_d = cnt_q + 4'd1;
               end
            end
         end
         S_STOP: begin
            if (tick) begin
               if (cnt_q == 4'd15) begin
                  if (sync2_q) push     = 1'b1;
                  else         ferr_set = 1'b1;
                  state_d = S_IDLE;
                  cnt_d   = 4'd0;
               end else begin
                  cnt_d = cnt_q + 4'd1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // FIFO control. A push into a full FIFO still lands when the same cycle pops.
   assign full    = (count_q == CW'(DEPTH));
   assign empty   = (count_q == '0);
   assign pop     = rd & ~empty;
   assign wr_en   = push & (~full | pop);
   assign ovr_set = push & full & ~rd;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (wr_en) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)   rd_ptr_d = rd_ptr_q + PW'(1);
      if (wr_en && !pop)      count_d = count_q + CW'(1);
      else if (pop && !wr_en) count_d = count_q - CW'(1);
      // Set beats clear when both happen in one cycle.
      ferr_d = ferr_set | (ferr_q & ~clr_err);
      ovr_d  = ovr_set  | (ovr_q  & ~clr_err);
   end

   always_ff @(posedge clock) begin
      if (!_reset) begin
         sync1_q  <= 1'b1;
         sync2_q  <= 1'b1;
         prev_q   <= 1'b1;
         pre_q    <= '0;
         state_q  <= S_IDLE;
         cnt_q    <= 4'd0;
         bit_q    <= 3'd0;
         shift_q  <= 8'h00;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ferr_q   <= 1'b0;
         ovr_q    <= 1'b0;
      end else begin
         sync1_q  <= rxd;
         sync2_q  <= sync1_q;
         prev_q   <= sync2_q;
         pre_q    <= tick ? '0 : pre_q + DW'(1);
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         bit_q    <= bit_d;
         shift_q  <= shift_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         ferr_q   <= ferr_d;
         ovr_q    <= ovr_d;
      end
   end

   // Storage needs no reset: data is masked to zero while empty.
   always_ff @(posedge clock) begin
      if (_reset && wr_en) mem_q[wr_ptr_q] <= shift_q;
   end

   assign data     = empty ? 8'h00 : mem_q[rd_ptr_q];
   assign rx_ready = ~empty;
   assign count    = count_q;
   assign ferr     = ferr_q;
   assign ovr      = ovr_q;
   assign irq      = irq_en & (~empty | ferr_q | ovr_q);
endmodule
